// File: rtl/vertical_timing_ctrl_if.sv
// Line-prefetch handshake between the vertical timing controller and the renderer.
`default_nettype none

interface vertical_timing_ctrl_if;
    logic       line_req;
    logic [8:0] line_num;
    logic       line_ack;

    modport master (output line_req, output line_num, input line_ack);
    modport slave  (input line_req, input line_num, output line_ack);
endinterface

`default_nettype wire

// File: rtl/vertical_timing_ctrl.sv
// ============================================================================
// Module   : vertical_timing_ctrl
// Brief    : VGA vertical counter, sync/blank, display enable, frame markers
//            and per-line prefetch request/ack handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module vertical_timing_ctrl #(
    parameter int H_VISIBLE     = 640,
    parameter int H_TOTAL       = 800,
    parameter int V_VISIBLE     = 480,
    parameter int V_FRONT_PORCH = 10,
    parameter int V_SYNC_PULSE  = 2,
    parameter int V_BACK_PORCH  = 33,
    parameter int V_TOTAL       = V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH
) (
    input  wire logic               clk,
    input  wire logic               reset,
    input  wire logic [10:0]        h_count,
    input  wire logic               underrun_clr,
    vertical_timing_ctrl_if.master  line_if,
    output logic [10:0]             v_count,
    output logic                    vsync,
    output logic                    vblank,
    output logic                    video_on,
    output logic                    frame_start,
    output logic [15:0]             frame_cnt,
    output logic                    underrun,
    output logic                    underrun_sticky
);

    localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_VIS      = 11'(V_VISIBLE);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] SYNC_START = 11'(V_VISIBLE + V_FRONT_PORCH);
    localparam logic [10:0] SYNC_END   = 11'(V_VISIBLE + V_FRONT_PORCH + V_SYNC_PULSE);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] v_count_q, v_count_d;
    logic        vsync_q, vsync_d;
    logic        vblank_q, vblank_d;
    logic        video_on_q, video_on_d;
    logic        frame_start_q, frame_start_d;
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic        line_req_q, line_req_d;
    logic [8:0]  line_num_q, line_num_d;
    logic        underrun_q, underrun_d;
    logic        sticky_q, sticky_d;

    logic        line_end;
    logic [10:0] v_next;

    always_comb begin
        line_end      = (h_count == H_LAST);
        v_next        = (v_count_q == V_LAST) ? 11'd0 : v_count_q + 11'd1;

        state_d       = state_q;
        v_count_d     = v_count_q;
        vsync_d       = vsync_q;
        vblank_d      = vblank_q;
        frame_start_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        line_req_d    = line_req_q;
        line_num_d    = line_num_q;
        underrun_d    = 1'b0;

        // Sync and blank follow the line being entered, not the one being left.
        if (line_end) begin
            v_count_d = v_next;
            vblank_d  = (v_next >= V_VIS);
            vsync_d   = !((v_next >= SYNC_START) && (v_next < SYNC_END));
            if (v_count_q == V_LAST) begin
                frame_start_d = 1'b1;
                frame_cnt_d   = frame_cnt_q + 16'd1;
            end
        end

        video_on_d = (h_count < H_VIS) && (v_count_q < V_VIS);

        case (state_q)
            ST_IDLE: begin
                if ((h_count == H_VIS) && (v_next < V_VIS)) begin
                    state_d    = ST_REQ;
                    line_req_d = 1'b1;
                    line_num_d = v_next[8:0];
                end
            end
            ST_REQ: begin
                // An ack coinciding with line end still counts as a completed fetch.
                if (line_if.line_ack) begin
                    state_d    = ST_IDLE;
                    line_req_d = 1'b0;
                end else if (line_end) begin
                    state_d    = ST_IDLE;
                    line_req_d = 1'b0;
                    underrun_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                line_req_d = 1'b0;
            end
        endcase

        if (underrun_d) begin
            sticky_d = 1'b1;
        end else if (underrun_clr) begin
            sticky_d = 1'b0;
        end else begin
            sticky_d = sticky_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            v_count_q     <= 11'd0;
            vsync_q       <= 1'b1;
            vblank_q      <= 1'b0;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 16'd0;
            line_req_q    <= 1'b0;
            line_num_q    <= 9'd0;
            underrun_q    <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            v_count_q     <= v_count_d;
            vsync_q       <= vsync_d;
            vblank_q      <= vblank_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
            line_req_q    <= line_req_d;
            line_num_q    <= line_num_d;
            underrun_q    <= underrun_d;
            sticky_q      <= sticky_d;
        end
    end

    assign v_count          = v_count_q;
    assign vsync            = vsync_q;
    assign vblank           = vblank_q;
    assign video_on         = video_on_q;
    assign frame_start      = frame_start_q;
    assign frame_cnt        = frame_cnt_q;
    assign line_if.line_req = line_req_q;
    assign line_if.line_num = line_num_q;
    assign underrun         = underrun_q;
    assign underrun_sticky  = sticky_q;

endmodule

`default_nettype wire

// File: tb/tb_vertical_timing_ctrl.sv
// Self-checking bench: randomized and directed h_count/ack/clr stimulus against a line-level reference model.
`default_nettype none

module tb_vertical_timing_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] h_count = 11'd0;
    logic        underrun_clr = 1'b0;
    logic [10:0] v_count;
    logic        vsync, vblank, video_on, frame_start, underrun, underrun_sticky;
    logic [15:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    vertical_timing_ctrl_if lif ();

    vertical_timing_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .h_count         (h_count),
        .underrun_clr    (underrun_clr),
        .line_if         (lif),
        .v_count         (v_count),
        .vsync           (vsync),
        .vblank          (vblank),
        .video_on        (video_on),
        .frame_start     (frame_start),
        .frame_cnt       (frame_cnt),
        .underrun        (underrun),
        .underrun_sticky (underrun_sticky)
    );

    always #5 clk = ~clk;

    // Reference model state: the line currently displayed and the fetch status.
    int m_line, m_fcnt, m_num;
    bit m_fs, m_von, m_req, m_und, m_sticky;

    task automatic model_reset();
        m_line = 0; m_fcnt = 0; m_num = 0;
        m_fs = 0; m_von = 0; m_req = 0; m_und = 0; m_sticky = 0;
    endtask

    task automatic model_step(input int h, input bit ack, input bit clr);
        int old_line;
        int upcoming;
        old_line = m_line;
        upcoming = (old_line + 1) % 525;
        m_fs  = 0;
        m_und = 0;
        if (h == 799) begin
            m_line = upcoming;
            if (m_line == 0) begin
                m_fs   = 1;
                m_fcnt = (m_fcnt + 1) % 65536;
            end
        end
        m_von = (h < 640) && (old_line < 480);
        if (m_req) begin
            if (ack) m_req = 0;
            else if (h == 799) begin
                m_req = 0;
                m_und = 1;
            end
        end else if (h == 640 && upcoming < 480) begin
            m_req = 1;
            m_num = upcoming;
        end
        if (m_und) m_sticky = 1;
        else if (clr) m_sticky = 0;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t line=%0d)", tag, got, exp, $time, m_line);
        end
    endtask

    task automatic check_all();
        check_eq("v_count", 32'(v_count), 32'(m_line));
        check_eq("vsync", 32'(vsync), 32'(!(m_line >= 490 && m_line <= 491)));
        check_eq("vblank", 32'(vblank), 32'(m_line >= 480));
        check_eq("video_on", 32'(video_on), 32'(m_von));
        check_eq("frame_start", 32'(frame_start), 32'(m_fs));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
        check_eq("line_req", 32'(lif.line_req), 32'(m_req));
        check_eq("line_num", 32'(lif.line_num), 32'(m_num));
        check_eq("underrun", 32'(underrun), 32'(m_und));
        check_eq("underrun_sticky", 32'(underrun_sticky), 32'(m_sticky));
    endtask

    // Inputs change just after a rising edge; outputs are sampled 1 ns after the next one.
    task automatic cycle(input int h, input bit ack, input bit clr);
        h_count      = 11'(h);
        lif.line_ack = ack;
        underrun_clr = clr;
        @(posedge clk);
        model_step(h, ack, clr);
        #1;
        check_all();
    endtask

    // mode 0: random; 1: ack 20 cycles after request; 2: no ack, clr at line end;
    // 3: ack only at line end; 4: no ack, early clr; 5: early clr then late ack
    task automatic run_line(input int mode);
        int  pct;
        bit  ack, clr;
        int  pcts [4] = '{0, 2, 10, 60};
        pct = pcts[$urandom_range(0, 3)];
        for (int h = 0; h < 800; h++) begin
            if (mode == 0 && $urandom_range(0, 99) == 0)
                cycle($urandom_range(800, 2047), 1'b0, 1'b0);
            ack = 0;
            clr = 0;
            case (mode)
                0: begin
                    ack = ($urandom_range(0, 99) < pct);
                    clr = ($urandom_range(0, 299) == 0);
                end
                1: ack = (h == 661);
                2: clr = (h == 799);
                3: ack = (h == 799);
                4: clr = (h == 100);
                5: begin
                    clr = (h == 100);
                    ack = (h == 700);
                end
                default: ;
            endcase
            cycle(h, ack, clr);
        end
    endtask

    task automatic skip_to(input int line);
        for (int n = 0; n < 600 && m_line != line; n++)
            cycle(799, 1'b0, 1'b0);
        check_eq("skip_reached", 32'(m_line), 32'(line));
    endtask

    initial begin
        model_reset();
        lif.line_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b0;

        for (int l = 0; l < 5; l++) run_line(0);
        run_line(1);
        run_line(0);
        run_line(2);
        run_line(5);
        run_line(3);
        run_line(4);
        for (int l = 0; l < 4; l++) run_line(0);

        skip_to(476);
        for (int l = 0; l < 18; l++) run_line(0);

        skip_to(521);
        for (int l = 0; l < 7; l++) run_line(0);

        // Reset while a request is outstanding
        skip_to(200);
        for (int h = 0; h <= 650; h++) cycle(h, 1'b0, 1'b0);
        check_eq("req_before_reset", 32'(m_req), 32'd1);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (2) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset = 1'b0;
        run_line(1);
        check_eq("first_num_after_reset", 32'(lif.line_num), 32'd1);
        run_line(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vertical_timing_ctrl.md
# vertical_timing_ctrl

Vertical timing and line-prefetch controller for the 640x480@60Hz VGA path. It sits directly downstream of the horizontal counter and consumes its `h_count` to produce the following:
- vertical line count, `vsync` and `vblank`;
- a combined display-enable;
- frame markers;
- a per-line req/ack handshake that tells the matrix renderer which visible line to fetch into its line buffer during horizontal blanking.

## Interface
Parameters:
- `H_VISIBLE`, 640: visible pixels per line.
- `H_TOTAL`, 800: pixels per line, including blanking.
- `V_VISIBLE`, 480: visible lines.
- `V_FRONT_PORCH`, 10: lines.
- `V_SYNC_PULSE`, 2: lines.
- `V_BACK_PORCH`, 33: lines.
- `V_TOTAL`, sum of the four vertical parameters (525): lines per frame.

Ports:
- `clk` in 1: pixel clock, shared with the horizontal counter.
- `reset` in 1: asynchronous, active-high reset.
- `h_count` in 11: horizontal pixel index 0..H_TOTAL-1 from the horizontal counter.
- `line_ack` in 1: renderer has accepted the current line request.
- `underrun_clr` in 1: clears `underrun_sticky`.
- `v_count` out 11: current line, 0..V_TOTAL-1.
- `vsync` out 1: vertical sync, active low.
- `vblank` out 1: high on non-visible lines.
- `video_on` out 1: registered display enable.
- `frame_start` out 1: one-cycle pulse at the start of each frame.
- `frame_cnt` out 16: frame counter, wraps.
- `line_req` out 1: line fetch request.
- `line_num` out 9: line to fetch; valid while `line_req` is high.
- `underrun` out 1: one-cycle pulse when a fetch is missed.
- `underrun_sticky` out 1: latched underrun flag.

## Operation
- Line advance occurs on the edge where `h_count == H_TOTAL-1`:
  - `v_count` increments, or wraps from V_TOTAL-1 to 0.
  - `v_count` therefore changes on the same edge where `h_count` returns to 0.
- `vblank` and `vsync` are registered from the next-line value on that same edge:
  - `vblank` = 1 for lines ≥ V_VISIBLE.
  - `vsync` = 0 for lines in [V_VISIBLE+V_FRONT_PORCH, V_VISIBLE+V_FRONT_PORCH+V_SYNC_PULSE), i.e. lines 490–491.
- `video_on` is registered every cycle as `(h_count < H_VISIBLE) && (v_count < V_VISIBLE)`. It therefore lags `h_count` by one cycle, aligned with the horizontal counter's registered blanking.
- `frame_start` pulses high on the edge where `v_count` wraps to 0. `frame_cnt` increments on that same edge and wraps at 65535→0.
- Fetch state machine, states IDLE and REQ:
  - **IDLE → REQ**: when `h_count == H_VISIBLE`, compute the target as `(v_count == V_TOTAL-1) ? 0 : v_count+1`. If target < V_VISIBLE, the next edge sets `line_req=1` and `line_num=target`. Otherwise stay in IDLE.
  - **REQ → IDLE**, ack: `line_ack` sampled high deasserts `line_req` on the next edge.
  - **REQ → IDLE**, underrun: if `h_count == H_TOTAL-1` with `line_ack` low, `line_req` drops, `underrun` pulses for one cycle, and `underrun_sticky` is set.
  - **Simultaneous events**: `line_ack` high together with `h_count == H_TOTAL-1` is an ack, not an underrun.
  - `line_ack` in IDLE is ignored.
  - `line_num` holds its last value after the request ends.
- `underrun_sticky` clear rules:
  - `underrun_clr` clears it.
  - If `underrun_clr` and a new underrun occur in the same cycle, set wins.
- After reset, line 0 of the first frame has no prefetch and is never flagged as an underrun.

## Timing
- Reset values: `v_count=0`, `vsync=1`, `vblank=0`, `video_on=0`, `frame_start=0`, `frame_cnt=0`, `line_req=0`, `line_num=0`, `underrun=0`, `underrun_sticky=0`, FSM in IDLE.
- Reset asserted mid-request drops `line_req` immediately (asynchronous). No underrun is reported.
- Latency:
  - `line_req` rises 1 cycle after `h_count == H_VISIBLE`.
  - `line_req` falls 1 cycle after `line_ack` is sampled.
  - Minimum request duration is 1 cycle, when `line_ack` is already high at the first sampling edge.
- `v_count`, `vsync`, `vblank` and `frame_start` all change on the edge where `h_count` goes H_TOTAL-1→0.
- `frame_start` is high for exactly one cycle every `H_TOTAL*V_TOTAL` = 420000 cycles.
- `h_count` is assumed to step by one each cycle. Any `h_count` value ≥ H_TOTAL causes no line advance and no FSM transition.

## Test plan
1. **Line and sync/blank timing.** Release reset and drive `h_count` 0..799 repeating. Required:
   - `v_count` increments only at 799→0.
   - `vblank` rises entering line 480.
   - `vsync` is low exactly for lines 490 and 491.
   - `v_count` wraps 524→0.
   - `frame_start` is a single pulse; `frame_cnt` goes 0→1.
2. **Display-enable alignment.** On line 10, `video_on` is high from the cycle after `h_count=0` through the cycle after `h_count=639`. It stays low on all of line 480.
3. **Normal handshake.** On line 5, hold `line_ack` low until 20 cycles after `line_req` rises, then pulse it for one cycle. Required:
   - `line_req` rises the cycle after `h_count=640` with `line_num=6`.
   - `line_req` falls the cycle after the ack.
   - No underrun.
   On line 524, the request is issued with `line_num=0`. On lines 479–523, no request is issued.
4. **Underrun.** On line 7, never assert `line_ack`. Required:
   - `line_req` drops after `h_count=799`.
   - `underrun` pulses once and `underrun_sticky=1`.
   - Pulsing `underrun_clr` clears it.
   - Asserting `underrun_clr` in the same cycle as a new underrun leaves `underrun_sticky=1`.
5. **Simultaneous ack at line end.** Assert `line_ack` exactly at `h_count=799`. Required: request completes, `underrun` stays 0, `v_count` advances normally.
6. **Reset mid-operation.** Assert `reset` while `line_req=1` on line 200. Required: all outputs take their reset values immediately. After release, counting restarts from `v_count=0` and the first request is for line 1.
